// File: rtl/gol_mem_pkg.sv
// Shared types and constants for the Game-of-Life data-RAM arbiter.
// Holds the arbiter state encoding, the byte-to-word shift and default parameters.
package gol_mem_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    CPU_RD = 1'b1
  } arb_state_t;

  localparam int WORD_OFF     = 2;
  localparam int DEF_AW       = 10;
  localparam int DEF_MAX_WAIT = 4;
  localparam int CNT_W        = 4;

endpackage

// File: rtl/gol_starve_cnt.sv
// Saturating wait counter for the video scanner.
// Raises force_vid once the scanner has been held off MAX_WAIT consecutive cycles.
module gol_starve_cnt
  import gol_mem_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vid_req,
  input  logic             vid_ready,
  output logic             force_vid,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_WAIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!vid_req || vid_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != SAT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_vid = vid_req && (wait_cnt == SAT);

endmodule

// File: rtl/gol_mem_arbiter.sv
// Single-port data RAM arbiter: RISC-V load/store port (fixed priority) vs video scanner.
// The starvation counter can push the scanner ahead; the core is then held via cpu_stall.
module gol_mem_arbiter
  import gol_mem_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [3:0]    cpu_be,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ready,
  output logic          vid_rvalid,
  output logic [31:0]   vid_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output arb_state_t    dbg_state
);

  // Handshake: a video read is accepted in the cycle vid_req && vid_ready; the
  // scanner holds vid_req/vid_addr stable until then, and data returns one cycle
  // later with a single-cycle vid_rvalid. The CPU side has no ready: cpu_stall
  // high means the core replays the same access next cycle.

  arb_state_t       state, state_nxt;
  logic             force_vid;
  logic [CNT_W-1:0] wait_cnt;
  logic             cpu_go, vid_go;
  logic [AW-1:0]    cpu_word;
  logic             unused_addr_bits;

  assign cpu_word         = cpu_addr[AW+WORD_OFF-1:WORD_OFF];
  assign unused_addr_bits = ^{cpu_addr[31:AW+WORD_OFF], cpu_addr[WORD_OFF-1:0], wait_cnt};

  gol_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .vid_req   (vid_req),
    .vid_ready (vid_ready),
    .force_vid (force_vid),
    .wait_cnt  (wait_cnt)
  );

  always_comb begin
    cpu_go    = 1'b0;
    vid_go    = 1'b0;
    cpu_stall = 1'b0;
    vid_ready = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    state_nxt = state;
    if (reset) begin
      if (state == CPU_RD) begin
        // Read data for the load issued last cycle; the port issues nothing new.
        cpu_rdata = mem_rdata;
        state_nxt = IDLE;
      end else begin
        cpu_go = cpu_req && !force_vid;
        vid_go = vid_req && !cpu_go;
        if (cpu_go) begin
          mem_addr = cpu_word;
          if (cpu_we) begin
            mem_we    = 1'b1;
            mem_be    = cpu_be;
            mem_wdata = cpu_wdata;
          end else begin
            cpu_stall = 1'b1;
            state_nxt = CPU_RD;
          end
        end else if (vid_go) begin
          vid_ready = 1'b1;
          mem_addr  = vid_addr;
          cpu_stall = cpu_req;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      vid_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      vid_rvalid <= vid_go;
    end
  end

  assign vid_rdata = vid_rvalid ? mem_rdata : 32'h0;
  assign dbg_state = state;

endmodule

// File: tb/tb_gol_mem_arbiter.sv
// Bench for gol_mem_arbiter: directed steps followed by randomized traffic,
// checked against a transaction-level model of the shared RAM and arbitration rules.
module tb_gol_mem_arbiter;
  import gol_mem_pkg::*;

  localparam int AW       = 10;
  localparam int MAX_WAIT = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cpu_req, cpu_we;
  logic [3:0]    cpu_be;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ready, vid_rvalid;
  logic [31:0]   vid_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;
  arb_state_t    dbg_state;

  gol_mem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ready  (vid_ready),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // environment RAM, synchronous read
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= ram[mem_addr];
  end

  // scoreboard / reference model state
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] exp_q[$];
  bit          m_rd;
  int          m_wait;
  bit          p_vid_go;
  logic [31:0] p_vid_data;
  bit          last_stall, last_vid_go;
  logic [31:0] s_cpu_rdata, s_vid_rdata;
  logic [AW-1:0] s_mem_addr;
  logic [3:0]  s_mem_be;
  logic        s_stall, s_vready, s_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wait = 0; p_vid_go = 0; last_stall = 0; last_vid_go = 0;
    exp_q.delete();
  endtask

  // One clock cycle with inputs already applied: predict, sample at negedge, advance.
  task automatic cycle();
    bit forced, cpu_go, vid_go, e_stall, e_vready, e_we;
    logic [31:0] e_rdata;
    int wa;
    wa = int'(cpu_addr[AW+1:2]);
    cpu_go = 0; vid_go = 0;
    if (m_rd) begin
      e_stall = 0; e_vready = 0; e_we = 0; e_rdata = exp_q.pop_front();
    end else begin
      forced   = vid_req && (m_wait == MAX_WAIT);
      cpu_go   = cpu_req && !forced;
      vid_go   = vid_req && !cpu_go;
      e_vready = vid_go;
      e_we     = cpu_go && cpu_we;
      e_stall  = cpu_req && !e_we;
      e_rdata  = 32'h0;
    end
    #4;
    s_cpu_rdata = cpu_rdata; s_vid_rdata = vid_rdata; s_mem_addr = mem_addr;
    s_mem_be = mem_be; s_stall = cpu_stall; s_vready = vid_ready; s_we = mem_we;
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, e_stall});
    chk("vid_ready", {31'b0, vid_ready}, {31'b0, e_vready});
    chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
    chk("cpu_rdata", cpu_rdata, e_rdata);
    chk("vid_rvalid", {31'b0, vid_rvalid}, {31'b0, p_vid_go});
    if (p_vid_go) chk("vid_rdata", vid_rdata, p_vid_data);
    if (cpu_go) chk("mem_addr_cpu", 32'(mem_addr), 32'(wa));
    if (vid_go) chk("mem_addr_vid", 32'(mem_addr), 32'(vid_addr));
    if (e_we) begin
      chk("mem_be", {28'b0, mem_be}, {28'b0, cpu_be});
      chk("mem_wdata", mem_wdata, cpu_wdata);
    end
    // model update for the coming edge
    if (e_we)
      for (int b = 0; b < 4; b++)
        if (cpu_be[b]) ref_mem[wa][8*b +: 8] = cpu_wdata[8*b +: 8];
    m_rd = cpu_go && !cpu_we;
    if (m_rd) exp_q.push_back(ref_mem[wa]);
    p_vid_go = vid_go;
    p_vid_data = ref_mem[vid_addr];
    if (!vid_req || vid_go) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    last_stall = e_stall;
    last_vid_go = vid_go;
    @(posedge clk); #1;
  endtask

  // driver helpers
  task automatic set_cpu(input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] data);
    cpu_req = req; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = data;
  endtask

  task automatic rand_cpu();
    logic [31:0] a;
    int lane;
    a = $urandom;
    a[AW+1:2] = AW'($urandom_range(0, 15));
    lane = $urandom_range(0, 3);
    cpu_req = ($urandom_range(0, 9) < 6);
    cpu_we = 1'($urandom_range(0, 1));
    if (cpu_we && $urandom_range(0, 1) == 1) begin
      a[1:0] = 2'(lane); cpu_be = 4'(1 << lane);
    end else begin
      a[1:0] = 2'b00; cpu_be = 4'hF;
    end
    cpu_addr = a; cpu_wdata = $urandom;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      #4;
      chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
      chk("rst_vready", {31'b0, vid_ready}, 32'h0);
      chk("rst_we", {31'b0, mem_we}, 32'h0);
      chk("rst_be", {28'b0, mem_be}, 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_rvalid", {31'b0, vid_rvalid}, 32'h0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i] = $urandom;
      ram[i] = ref_mem[i];
    end
    ref_mem[7] = 32'h1234_5678;
    ram[7] = 32'h1234_5678;
    reset = 1'b0;
    set_cpu(1, 0, 4'hF, 32'h10, 32'h0);
    vid_req = 1'b1; vid_addr = AW'(2);
    @(posedge clk); #1;

    // reset with both requesters active, then CPU wins the first cycle
    reset_cycles(2);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    cycle();
    chk("first_cpu_grant_stall", {31'b0, s_stall}, 32'h1);
    chk("first_cpu_grant_vready", {31'b0, s_vready}, 32'h0);
    cycle();
    cpu_req = 0;
    cycle();
    vid_req = 0;
    cycle();

    // sw then lw of the same word
    set_cpu(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    cycle();
    chk("sw_addr", 32'(s_mem_addr), 32'h4);
    chk("sw_stall", {31'b0, s_stall}, 32'h0);
    set_cpu(1, 0, 4'hF, 32'h10, 32'h0);
    cycle();
    cycle();
    chk("lw_data", s_cpu_rdata, 32'hDEAD_BEEF);
    chk("lw_stall_rd", {31'b0, s_stall}, 32'h0);

    // idle CPU, video read of word 7
    cpu_req = 0; vid_req = 1; vid_addr = AW'(7);
    cycle();
    chk("vid7_ready", {31'b0, s_vready}, 32'h1);
    vid_req = 0;
    cycle();
    chk("vid7_data", s_vid_rdata, 32'h1234_5678);

    // back-to-back stores starve the scanner until it is forced
    vid_req = 1; vid_addr = AW'(3);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      if (!last_stall) set_cpu(1, 1, 4'hF, 32'h40, $urandom);
      cycle();
      if (s_vready) begin n = k; break; end
    end
    chk("starve_cycle", 32'(n), 32'h5);
    chk("starve_stall", {31'b0, s_stall}, 32'h1);
    vid_req = 0;
    cycle();
    chk("starve_retry_we", {31'b0, s_we}, 32'h1);

    // reset while a CPU read is returning
    set_cpu(1, 0, 4'hF, 32'h10, 32'h0);
    cycle();
    reset = 0;
    #4;
    chk("rdrst_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rdrst_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1; cpu_req = 0;
    model_reset();
    chk("rdrst_state", 32'(dbg_state), 32'(IDLE));
    // reset landing on the edge after a video grant discards the read
    vid_req = 1; vid_addr = AW'(5);
    #4;
    chk("vrst_ready", {31'b0, vid_ready}, 32'h1);
    #1 reset = 0;
    @(posedge clk); #1;
    chk("vrst_rvalid", {31'b0, vid_rvalid}, 32'h0);
    vid_req = 0;
    @(posedge clk); #1;
    chk("vrst_rvalid2", {31'b0, vid_rvalid}, 32'h0);
    reset = 1;
    model_reset();

    // sb to byte 3 of word 4 (holds DEADBEEF)
    set_cpu(1, 1, 4'b1000, 32'h13, 32'h0000_00AA);
    cycle();
    chk("sb_be", {28'b0, s_mem_be}, 32'h8);
    chk("sb_addr", 32'(s_mem_addr), 32'h4);
    set_cpu(1, 0, 4'hF, 32'h10, 32'h0);
    cycle();
    cycle();
    chk("sb_lw", s_cpu_rdata, 32'h00AD_BEEF);
    cpu_req = 0;
    cycle();

    // randomized traffic obeying the hold-while-stalled / hold-until-ready rules
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) rand_cpu();
      if (!vid_req || last_vid_go) begin
        vid_req = ($urandom_range(0, 1) == 1);
        vid_addr = AW'($urandom_range(0, 15));
      end
      cycle();
    end
    cpu_req = 0; vid_req = 0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
